// File: rtl/ahb_burst_master.sv
// rtl/ahb_burst_master.sv - command-driven AHB-Lite burst master
//
// Purpose:
//   Accepts one burst command at a time and runs it on AHB-Lite as word
//   transfers: NONSEQ then SEQ beats, with the address and data phases
//   pipelined and every step stalled by hready. Write data is pulled from a
//   local source (wr_req/wr_data). Read data is presented on rd_data with a
//   one-cycle rd_valid strobe. done pulses when the burst ends. err pulses
//   together with done when an ERROR response aborts the burst.
//
// Configuration macro:
//   AHB_MASTER_WRAP_EN - when defined, WRAP4/8/16 wrap at the burst-size
//   boundary. Otherwise they run as linear INCR bursts of the same length.
//
// Ports:
//   hclk, hreset            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_addr/write/burst    start address, direction, hburst code
//   wr_req, wr_data         write-data pull (consumed when wr_req=1)
//   rd_valid, rd_data       read beat output
//   done, err               end-of-burst pulses
//   hsel, haddr, htrans,
//   hburst, hwrite, hsize,
//   hmastlock, hwdata       AHB master outputs
//   hready, hresp, hrdata   AHB slave responses
module ahb_burst_master #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic              cmd_write,
  input  logic [2:0]        cmd_burst,
  output logic              wr_req,
  input  logic [DWIDTH-1:0] wr_data,
  output logic              rd_valid,
  output logic [DWIDTH-1:0] rd_data,
  output logic              done,
  output logic              err,
  output logic              hsel,
  output logic [AWIDTH-1:0] haddr,
  output logic [1:0]        htrans,
  output logic [2:0]        hburst,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic              hmastlock,
  output logic [DWIDTH-1:0] hwdata,
  input  logic              hready,
  input  logic [1:0]        hresp,
  input  logic [DWIDTH-1:0] hrdata
);

  // ST_ADDR: first (NONSEQ) address phase, no data phase outstanding.
  // ST_SEQ : SEQ address phase overlapping the previous beat's data phase.
  // ST_LAST: only the final data phase is outstanding, htrans is IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_SEQ  = 2'd2,
    ST_LAST = 2'd3
  } state_e;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] haddr_q, haddr_d;
  logic [1:0]        htrans_q, htrans_d;
  logic [2:0]        hburst_q, hburst_d;
  logic              hwrite_q, hwrite_d;
  logic [DWIDTH-1:0] hwdata_q, hwdata_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DWIDTH-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [4:0]        beats_m1;
  logic [AWIDTH-1:0] addr_inc;
  logic [AWIDTH-1:0] next_addr;
  logic              data_phase;
  logic              data_done;
  logic              err_now;

  // hburst[2:1] encodes the length for both INCRx and WRAPx; INCR (001)
  // falls into the 00 group and therefore runs as a single beat.
  always_comb begin
    case (hburst_q[2:1])
      2'b00:   beats_m1 = 5'd0;
      2'b01:   beats_m1 = 5'd3;
      2'b10:   beats_m1 = 5'd7;
      default: beats_m1 = 5'd15;
    endcase
  end

  assign addr_inc = haddr_q + {{(AWIDTH-3){1'b0}}, 3'b100};

`ifdef AHB_MASTER_WRAP_EN
  logic              is_wrap;
  logic [AWIDTH-1:0] wrap_mask;

  // Even non-zero codes are the WRAP variants; the mask spans beats*4 bytes.
  assign is_wrap   = ~hburst_q[0] & (hburst_q[2:1] != 2'b00);
  assign wrap_mask = {{(AWIDTH-7){1'b0}}, beats_m1, 2'b11};
  assign next_addr = is_wrap ? ((haddr_q & ~wrap_mask) | (addr_inc & wrap_mask))
                             : addr_inc;
`else
  assign next_addr = addr_inc;
`endif

  assign data_phase = (state_q == ST_SEQ) || (state_q == ST_LAST);
  assign data_done  = data_phase && hready;
  assign err_now    = data_done && (hresp == 2'b01);

  always_comb begin
    state_d    = state_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hburst_d   = hburst_q;
    hwrite_d   = hwrite_q;
    hwdata_d   = hwdata_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    wr_req     = 1'b0;

    // An errored read beat is never forwarded.
    if (data_done && !hwrite_q && !err_now) begin
      rd_data_d  = hrdata;
      rd_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = 5'd0;
        if (cmd_valid) begin
          state_d  = ST_ADDR;
          haddr_d  = cmd_addr & {{(AWIDTH-2){1'b1}}, 2'b00};
          htrans_d = TR_NONSEQ;
          hburst_d = cmd_burst;
          hwrite_d = cmd_write;
        end
      end
      ST_ADDR, ST_SEQ: begin
        if (err_now) begin
          // The address phase completing alongside the error is discarded.
          state_d  = ST_IDLE;
          htrans_d = TR_IDLE;
          done_d   = 1'b1;
          err_d    = 1'b1;
        end else if (hready) begin
          if (hwrite_q) begin
            wr_req   = 1'b1;
            hwdata_d = wr_data;
          end
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == beats_m1) begin
            state_d  = ST_LAST;
            htrans_d = TR_IDLE;
          end else begin
            state_d  = ST_SEQ;
            htrans_d = TR_SEQ;
            haddr_d  = next_addr;
          end
        end
      end
      ST_LAST: begin
        if (data_done) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          err_d   = err_now;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        htrans_d = TR_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state_q    <= ST_IDLE;
      haddr_q    <= '0;
      htrans_q   <= TR_IDLE;
      hburst_q   <= 3'b000;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      cnt_q      <= 5'd0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hburst_q   <= hburst_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign hsel      = htrans_q[1];
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hburst    = hburst_q;
  assign hwrite    = hwrite_q;
  assign hsize     = 3'b010;
  assign hmastlock = 1'b0;
  assign hwdata    = hwdata_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// tb/tb_ahb_burst_master.sv - scoreboard bench for ahb_burst_master
module tb_ahb_burst_master;

  logic        hclk = 1'b0;
  logic        hreset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic        cmd_write = 1'b0;
  logic [2:0]  cmd_burst = '0;
  logic        wr_req;
  logic [31:0] wr_data = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hready = 1'b0;
  logic [1:0]  hresp = 2'b00;
  logic [31:0] hrdata = '0;

  int total = 0;
  int bad = 0;

  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_wd_q[$];

  ahb_burst_master #(.AWIDTH(32), .DWIDTH(32)) dut (
    .hclk(hclk), .hreset(hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_burst(cmd_burst),
    .wr_req(wr_req), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .done(done), .err(err),
    .hsel(hsel), .haddr(haddr), .htrans(htrans), .hburst(hburst),
    .hwrite(hwrite), .hsize(hsize), .hmastlock(hmastlock), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;

  function automatic int model_beats(input logic [2:0] burst);
    case (burst)
      3'b010, 3'b011: return 4;
      3'b100, 3'b101: return 8;
      3'b110, 3'b111: return 16;
      default:        return 1;
    endcase
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] start,
                                             input logic [2:0] burst, input int k);
    logic [31:0] s;
    s = {start[31:2], 2'b00};
`ifdef AHB_MASTER_WRAP_EN
    if (burst == 3'b010 || burst == 3'b100 || burst == 3'b110) begin
      logic [31:0] span;
      logic [31:0] base;
      span = 32'(4 * model_beats(burst));
      base = s - (s % span);
      return base + ((s - base + 32'(4 * k)) % span);
    end
`endif
    return s + 32'(4 * k);
  endfunction

  // Asserts reset from wherever the bus is and checks every output at once.
  task automatic test_reset();
    hreset = 1'b0;
    hready = 1'b0;
    hresp  = 2'b00;
    cmd_valid = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset cmd_ready got=%b exp=1", cmd_ready); end
    total++; if (htrans !== 2'b00) begin bad++; $display("FAIL reset htrans got=%b exp=00", htrans); end
    total++; if (hsel !== 1'b0) begin bad++; $display("FAIL reset hsel got=%b exp=0", hsel); end
    total++; if (haddr !== 32'h0) begin bad++; $display("FAIL reset haddr got=%h exp=0", haddr); end
    total++; if (hburst !== 3'b000) begin bad++; $display("FAIL reset hburst got=%b exp=000", hburst); end
    total++; if (hwrite !== 1'b0) begin bad++; $display("FAIL reset hwrite got=%b exp=0", hwrite); end
    total++; if (hwdata !== 32'h0) begin bad++; $display("FAIL reset hwdata got=%h exp=0", hwdata); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL reset rd_data got=%h exp=0", rd_data); end
    total++; if ({wr_req, rd_valid, done, err} !== 4'b0000) begin bad++; $display("FAIL reset pulses got=%b exp=0000", {wr_req, rd_valid, done, err}); end
    total++; if (hsize !== 3'b010) begin bad++; $display("FAIL reset hsize got=%b exp=010", hsize); end
    total++; if (hmastlock !== 1'b0) begin bad++; $display("FAIL reset hmastlock got=%b exp=0", hmastlock); end
    for (int i = 0; i < 2; i++) begin
      @(negedge hclk);
      #1;
      total++; if ({done, err, htrans} !== 4'b0000) begin bad++; $display("FAIL reset_hold done/err/htrans got=%b exp=0000", {done, err, htrans}); end
    end
    @(negedge hclk);
    hreset = 1'b1;
  endtask

  // Issues one command and plays the slave until done; expected bus values
  // come from the address model and the read/write scoreboards.
  task automatic run_burst(input string name, input logic [31:0] addr, input logic wr,
                           input logic [2:0] burst, input int stall_beat, input int stall_n,
                           input int err_beat, input logic [31:0] wbase, input logic [31:0] rbase,
                           input int exp_wr_cnt, input int exp_rd_cnt, input logic exp_err);
    int nb, a_idx, d_idx, stall_left, wr_cnt, rd_cnt, cyc;
    logic a_active, done_due, err_due, err_now, finished, exp_wreq;
    logic [31:0] ea, e;
    nb = model_beats(burst);
    a_idx = 0; d_idx = -1; stall_left = stall_n;
    wr_cnt = 0; rd_cnt = 0; cyc = 0;
    a_active = 1'b1; done_due = 1'b0; err_due = 1'b0; finished = 1'b0;
    exp_rd_q.delete();
    exp_wd_q.delete();

    cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr; cmd_burst = burst;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s cmd_ready_before got=%b exp=1", name, cmd_ready); end

    while (!finished && cyc < 300) begin
      @(negedge hclk);
      cyc++;
      cmd_valid = 1'b0;
      hready = 1'b1;
      if (a_active && a_idx == stall_beat && stall_left > 0) begin
        hready = 1'b0;
        stall_left--;
      end
      err_now = (d_idx >= 0) && hready && (d_idx == err_beat);
      hresp   = err_now ? 2'b01 : 2'b00;
      hrdata  = (d_idx >= 0) ? rbase + 32'(d_idx) : 32'hDEAD_BEEF;
      wr_data = wbase + 32'(a_idx);
      #1;

      total++; if (done !== done_due) begin bad++; $display("FAIL %s done cyc=%0d got=%b exp=%b", name, cyc, done, done_due); end
      total++; if (err !== err_due) begin bad++; $display("FAIL %s err cyc=%0d got=%b exp=%b", name, cyc, err, err_due); end
      total++; if (cmd_ready !== done_due) begin bad++; $display("FAIL %s cmd_ready cyc=%0d got=%b exp=%b", name, cyc, cmd_ready, done_due); end

      if (rd_valid === 1'b1) begin
        rd_cnt++;
        total++;
        if (exp_rd_q.size() == 0) begin
          bad++; $display("FAIL %s rd_valid unexpected got=%h", name, rd_data);
        end else begin
          e = exp_rd_q.pop_front();
          if (rd_data !== e) begin bad++; $display("FAIL %s rd_data got=%h exp=%h", name, rd_data, e); end
        end
      end

      if (a_active) begin
        ea = model_addr(addr, burst, a_idx);
        total++; if (haddr !== ea) begin bad++; $display("FAIL %s haddr beat=%0d got=%h exp=%h", name, a_idx, haddr, ea); end
        total++; if (htrans !== ((a_idx == 0) ? 2'b10 : 2'b11)) begin bad++; $display("FAIL %s htrans beat=%0d got=%b", name, a_idx, htrans); end
        total++; if (hsel !== 1'b1) begin bad++; $display("FAIL %s hsel got=%b exp=1", name, hsel); end
        total++; if (hburst !== burst || hwrite !== wr) begin bad++; $display("FAIL %s hburst/hwrite got=%b/%b exp=%b/%b", name, hburst, hwrite, burst, wr); end
      end else begin
        total++; if (htrans !== 2'b00 || hsel !== 1'b0) begin bad++; $display("FAIL %s idle htrans/hsel got=%b/%b exp=00/0", name, htrans, hsel); end
      end

      exp_wreq = a_active && hready && wr && !err_now;
      total++; if (wr_req !== exp_wreq) begin bad++; $display("FAIL %s wr_req cyc=%0d got=%b exp=%b", name, cyc, wr_req, exp_wreq); end
      if (wr_req === 1'b1) wr_cnt++;

      if (d_idx >= 0 && wr) begin
        total++;
        if (exp_wd_q.size() == 0) begin
          bad++; $display("FAIL %s hwdata no expected value got=%h", name, hwdata);
        end else if (hwdata !== exp_wd_q[0]) begin
          bad++; $display("FAIL %s hwdata beat=%0d got=%h exp=%h", name, d_idx, hwdata, exp_wd_q[0]);
        end
      end

      if (done_due) begin
        finished = 1'b1;
      end else if (hready) begin
        if (d_idx >= 0) begin
          if (!wr && !err_now) exp_rd_q.push_back(hrdata);
          if (wr && exp_wd_q.size() > 0) void'(exp_wd_q.pop_front());
          if (err_now || d_idx == nb - 1) begin
            done_due = 1'b1;
            err_due  = err_now;
          end
          d_idx = -1;
        end
        if (err_now) begin
          a_active = 1'b0;
        end else if (a_active) begin
          if (wr) exp_wd_q.push_back(wr_data);
          d_idx = a_idx;
          a_idx++;
          if (a_idx == nb) a_active = 1'b0;
        end
      end
    end

    if (!finished) begin
      total++; bad++;
      $display("FAIL %s timeout waiting for done", name);
    end
    total++; if (wr_cnt != exp_wr_cnt) begin bad++; $display("FAIL %s wr_req_count got=%0d exp=%0d", name, wr_cnt, exp_wr_cnt); end
    total++; if (rd_cnt != exp_rd_cnt) begin bad++; $display("FAIL %s rd_valid_count got=%0d exp=%0d", name, rd_cnt, exp_rd_cnt); end
    total++; if (exp_rd_q.size() != 0) begin bad++; $display("FAIL %s read_left got=%0d exp=0", name, exp_rd_q.size()); end
    total++; if (err_due !== exp_err) begin bad++; $display("FAIL %s error_outcome got=%b exp=%b", name, err_due, exp_err); end
  endtask

  task automatic test_single_write();
    run_burst("single_wr", 32'h0000_0040, 1'b1, 3'b000, 0, 3, -1,
              32'hA5A5_0001, 32'h0, 1, 0, 1'b0);
  endtask

  task automatic test_incr4_read();
    run_burst("incr4_rd", 32'h0000_0100, 1'b0, 3'b011, -1, 0, -1,
              32'h0, 32'h1, 0, 4, 1'b0);
  endtask

  task automatic test_incr8_write_stall();
    run_burst("incr8_wr_stall", 32'h0000_0200, 1'b1, 3'b101, 2, 2, -1,
              32'h1000_0000, 32'h0, 8, 0, 1'b0);
  endtask

  task automatic test_wrap4_read();
    run_burst("wrap4_rd", 32'h0000_0038, 1'b0, 3'b010, -1, 0, -1,
              32'h0, 32'h50, 0, 4, 1'b0);
  endtask

  task automatic test_incr16_error();
    run_burst("incr16_err", 32'h0000_0400, 1'b0, 3'b111, -1, 0, 4,
              32'h0, 32'h70, 0, 4, 1'b1);
  endtask

  task automatic test_reset_mid_burst();
    cmd_valid = 1'b1; cmd_addr = 32'h0000_0200; cmd_write = 1'b1; cmd_burst = 3'b101;
    @(posedge hclk);
    for (int i = 0; i < 2; i++) begin
      @(negedge hclk);
      cmd_valid = 1'b0;
      hready = 1'b1;
      hresp = 2'b00;
      wr_data = 32'h7700_0000 + 32'(i);
    end
    @(negedge hclk);
    hready = 1'b0;
    #1;
    total++; if (htrans !== 2'b11 || haddr !== 32'h0000_0208) begin bad++; $display("FAIL mid_burst pre_reset htrans/haddr got=%b/%h exp=11/00000208", htrans, haddr); end
    test_reset();
    run_burst("after_reset_wr", 32'h0000_0080, 1'b1, 3'b000, 0, 2, -1,
              32'hC0DE_0000, 32'h0, 1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_burst("b2b_incr4_wr", 32'h0000_0300, 1'b1, 3'b011, 1, 1, -1,
              32'h3300_0000, 32'h0, 4, 0, 1'b0);
    run_burst("b2b_single_rd", 32'h0000_0503, 1'b0, 3'b001, -1, 0, -1,
              32'h0, 32'h9900_0000, 0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr4_read();
    test_incr8_write_stall();
    test_wrap4_read();
    test_incr16_error();
    test_reset_mid_burst();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
